// File: rtl/spi_register_bridge_if.sv
// Byte-stream link between the SPI peripheral (master side) and the register bridge (slave side).
interface spi_register_bridge_if;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic [7:0] tx_byte;
  logic       tx_dv;

  modport master (output rx_byte, rx_dv, input tx_byte, tx_dv);
  modport slave  (input rx_byte, rx_dv, output tx_byte, tx_dv);
endinterface

// File: rtl/spi_register_bridge.sv
// Decodes SPI frames ({rw, addr} command then data bytes) into burst reads and writes
// of a small register bank whose register 0 is a read-only ID.
module spi_register_bridge #(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_spi_cs_n,
  spi_register_bridge_if.slave           bus,
  output logic [8*(2**ADDR_WIDTH)-1:0]   o_regs,
  output logic                           o_wr_strobe,
  output logic [ADDR_WIDTH-1:0]          o_wr_addr,
  output logic                           o_frame_active,
  output logic                           o_addr_error
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  state_t                r_state, w_state_next;
  logic                  r_cs_meta, r_cs_sync, r_cs_prev;
  logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_next;
  logic [7:0]            r_tx_byte, w_tx_byte_next;
  logic                  r_tx_dv, w_tx_dv_next;
  logic                  r_wr_strobe, w_wr_strobe_next;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_next;
  logic                  r_frame_active, w_frame_active_next;
  logic                  r_addr_error, w_addr_error_next;
  logic [7:0]            w_reg_view [0:NUM_REGS-1];

  wire                  w_cs_fall    = r_cs_prev & ~r_cs_sync;
  wire                  w_cs_rise    = ~r_cs_prev & r_cs_sync;
  wire [ADDR_WIDTH-1:0] w_cmd_addr   = bus.rx_byte[ADDR_WIDTH-1:0];
  wire                  w_cmd_bad    = {1'b0, bus.rx_byte[6:0]} >= 8'(NUM_REGS);
  wire [7:0]            w_rd_data    = w_reg_view[r_ptr];
  wire [7:0]            w_cmd_rd     = w_reg_view[w_cmd_addr];

  // Register 0 is the constant ID; the rest are writable flops updated alongside o_wr_strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign w_reg_view[gi] = ID_VALUE;
      end else begin : g_rw
        logic [7:0] r_reg;
        always_ff @(posedge i_clk or negedge i_reset_n) begin
          if (!i_reset_n)
            r_reg <= 8'h00;
          else if (w_wr_strobe_next && w_wr_addr_next == ADDR_WIDTH'(gi))
            r_reg <= bus.rx_byte;
        end
        assign w_reg_view[gi] = r_reg;
      end
      assign o_regs[8*gi +: 8] = w_reg_view[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cs_meta      <= 1'b1;
      r_cs_sync      <= 1'b1;
      r_cs_prev      <= 1'b1;
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_tx_byte      <= 8'h00;
      r_tx_dv        <= 1'b0;
      r_wr_strobe    <= 1'b0;
      r_wr_addr      <= '0;
      r_frame_active <= 1'b0;
      r_addr_error   <= 1'b0;
    end else begin
      r_cs_meta      <= i_spi_cs_n;
      r_cs_sync      <= r_cs_meta;
      r_cs_prev      <= r_cs_sync;
      r_state        <= w_state_next;
      r_ptr          <= w_ptr_next;
      r_tx_byte      <= w_tx_byte_next;
      r_tx_dv        <= w_tx_dv_next;
      r_wr_strobe    <= w_wr_strobe_next;
      r_wr_addr      <= w_wr_addr_next;
      r_frame_active <= w_frame_active_next;
      r_addr_error   <= w_addr_error_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_ptr_next          = r_ptr;
    w_tx_byte_next      = r_tx_byte;
    w_tx_dv_next        = 1'b0;
    w_wr_strobe_next    = 1'b0;
    w_wr_addr_next      = r_wr_addr;
    w_frame_active_next = r_frame_active;
    w_addr_error_next   = r_addr_error;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_next        = CMD;
          w_tx_dv_next        = 1'b1;
          w_tx_byte_next      = ID_VALUE;
          w_addr_error_next   = 1'b0;
          w_frame_active_next = 1'b1;
        end
      end
      CMD: begin
        if (bus.rx_dv) begin
          if (w_cmd_bad) begin
            w_addr_error_next = 1'b1;
            w_state_next      = DISCARD;
            if (bus.rx_byte[7]) begin
              w_tx_dv_next   = 1'b1;
              w_tx_byte_next = 8'h00;
            end
          end else if (bus.rx_byte[7]) begin
            w_state_next   = READ;
            w_ptr_next     = w_cmd_addr + 1'b1;
            w_tx_dv_next   = 1'b1;
            w_tx_byte_next = w_cmd_rd;
          end else begin
            w_state_next = WRITE;
            w_ptr_next   = w_cmd_addr;
          end
        end
      end
      WRITE: begin
        if (bus.rx_dv) begin
          if (r_ptr != '0) begin
            w_wr_strobe_next = 1'b1;
            w_wr_addr_next   = r_ptr;
          end
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      READ: begin
        if (bus.rx_dv) begin
          w_tx_dv_next   = 1'b1;
          w_tx_byte_next = w_rd_data;
          w_ptr_next     = r_ptr + 1'b1;
        end
      end
      DISCARD: ;
      default: w_state_next = IDLE;
    endcase
    // End of frame overrides the state only; a byte arriving in this cycle is already handled.
    if (w_cs_rise) begin
      w_state_next        = IDLE;
      w_frame_active_next = 1'b0;
    end
  end

  assign bus.tx_byte     = r_tx_byte;
  assign bus.tx_dv       = r_tx_dv;
  assign o_wr_strobe     = r_wr_strobe;
  assign o_wr_addr       = r_wr_addr;
  assign o_frame_active  = r_frame_active;
  assign o_addr_error    = r_addr_error;
endmodule
